uart_tx_param: RTL and testbench

Parametrised UART transmitter, the next generation of the fixed 8N1/8E1/8O1 transmitter. It serialises words of configurable width with run-time parity and stop-bit selection, and uses a valid/ready input handshake. It supports back-to-back frames with no idle gap. It sits between any byte/word producer (CPU bridge, packetiser) and the board TX pin.

---
 rtl/uart_tx_param.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable word width, run-time parity and stop bits, valid/ready input.
// Define UART_TX_FIFO_EN to buffer words in a FIFO_DEPTH-entry FIFO instead of a single holding register.
module uart_tx_param #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUDRATE    = 9600,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  input  logic                          pen,
  input  logic                          peven,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int BIT_CYC = (CLK_FREQ_HZ + BAUDRATE / 2) / BAUDRATE;
  localparam int CNT_W   = $clog2(2 * BIT_CYC);
  localparam int BIT_W   = $clog2(DATA_BITS + 1);
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] STOP2_LAST = CNT_W'(2 * BIT_CYC - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_tx_param: DATA_BITS must be within 5..9");
    end
    if (BIT_CYC < 2) begin : g_bad_baud
      $error("uart_tx_param: CLK_FREQ_HZ/BAUDRATE must round to at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic                 push;
  logic                 pop;
  logic                 avail;
  logic [LVL_W-1:0]     level_reg;
  logic [DATA_BITS-1:0] rd_data_reg;

  assign push  = s_valid && s_ready;
  assign avail = (level_reg != '0);
  assign level = level_reg;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign s_ready = rst && (level_reg < LVL_W'(FIFO_DEPTH));
`else
  logic [DATA_BITS-1:0] hold_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      hold_reg <= s_data;
    end
    if (pop) begin
      rd_data_reg <= hold_reg;
    end
  end

  // Push only happens while empty and pop only while full, so they never coincide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_reg <= '0;
    end else if (push) begin
      level_reg <= LVL_W'(1);
    end else if (pop) begin
      level_reg <= '0;
    end
  end

  assign s_ready = rst && (level_reg == '0);
`endif

  state_t               state_reg,  state_next;
  logic [CNT_W-1:0]     cnt_reg,    cnt_next;
  logic [BIT_W-1:0]     bit_reg,    bit_next;
  logic [DATA_BITS-1:0] shift_reg,  shift_next;
  logic                 parity_reg, parity_next;
  logic                 pen_reg,    pen_next;
  logic                 peven_reg,  peven_next;
  logic                 stop2_reg,  stop2_next;
  logic                 tx_reg,     tx_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      pen_reg    <= 1'b0;
      peven_reg  <= 1'b0;
      stop2_reg  <= 1'b0;
      tx_reg     <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      pen_reg    <= pen_next;
      peven_reg  <= peven_next;
      stop2_reg  <= stop2_next;
      tx_reg     <= tx_next;
    end
  end

  // tx_next is the line value for the cycle that follows the current edge.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + 1'b1;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    pen_next    = pen_reg;
    peven_next  = peven_reg;
    stop2_next  = stop2_reg;
    tx_next     = tx_reg;
    pop         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        tx_next  = 1'b1;
        if (avail) begin
          state_next = ST_START;
          pop        = 1'b1;
          pen_next   = pen;
          peven_next = peven;
          stop2_next = stop2;
          tx_next    = 1'b0;
        end
      end

      ST_START: begin
        // The word popped at frame start lands in rd_data_reg one cycle later.
        if (cnt_reg == '0) begin
          shift_next  = rd_data_reg;
          parity_next = (^rd_data_reg) ^ !peven_reg;
        end
        if (cnt_reg == BIT_LAST) begin
          state_next = ST_DATA;
          cnt_next   = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
        end
      end

      ST_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (bit_reg == DATA_LAST) begin
            if (pen_reg) begin
              state_next = ST_PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end
      end

      ST_PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          state_next = ST_STOP;
          cnt_next   = '0;
          tx_next    = 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_reg == (stop2_reg ? STOP2_LAST : BIT_LAST)) begin
          cnt_next = '0;
          if (avail) begin
            state_next = ST_START;
            pop        = 1'b1;
            pen_next   = pen;
            peven_next = peven;
            stop2_next = stop2;
            tx_next    = 1'b0;
          end else begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx   = tx_reg;
  assign busy = (state_reg != ST_IDLE) || avail;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: line waveforms are compared cycle by cycle against a frame model.
module tb_uart_tx_param;

  localparam int BC    = 10;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_FIFO_EN
  localparam int EXP_FIRST_ACCEPTS = 5;
  localparam int EXP_DROP_LEVEL    = 4;
`else
  localparam int EXP_FIRST_ACCEPTS = 1;
  localparam int EXP_DROP_LEVEL    = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pen = 1'b0, peven = 1'b0, stop2 = 1'b0;

  logic          s_valid_a = 1'b0;
  logic [7:0]    s_data_a  = '0;
  logic          s_ready_a, tx_a, busy_a;
  logic [LW-1:0] level_a;

  logic          s_valid_b = 1'b0;
  logic [4:0]    s_data_b  = '0;
  logic          s_ready_b, tx_b, busy_b;
  logic [LW-1:0] level_b;

  int nvec = 0;
  int nerr = 0;

  bit   exp_q[$];
  logic cap_tx[$];
  logic cap_busy[$];

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ_HZ(1000), .BAUDRATE(100), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_data(s_data_a), .s_ready(s_ready_a),
    .pen(pen), .peven(peven), .stop2(stop2), .tx(tx_a), .busy(busy_a), .level(level_a)
  );

  uart_tx_param #(.CLK_FREQ_HZ(1000), .BAUDRATE(100), .DATA_BITS(5), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_data(s_data_b), .s_ready(s_ready_b),
    .pen(pen), .peven(peven), .stop2(stop2), .tx(tx_b), .busy(busy_b), .level(level_b)
  );

  function automatic int flen(input int nb, input bit p, input bit s2);
    return BC * (2 + nb + int'(p) + int'(s2));
  endfunction

  // Frame model: start, data LSB first, parity from the count of ones, stop bits.
  task automatic model_frame(input int nb, input logic [8:0] d, input bit p, input bit pe, input bit s2);
    int ones;
    bit pb;
    ones = 0;
    for (int i = 0; i < BC; i++) exp_q.push_back(1'b0);
    for (int b = 0; b < nb; b++) begin
      if (d[b]) ones++;
      for (int i = 0; i < BC; i++) exp_q.push_back(d[b]);
    end
    if (p) begin
      pb = pe ? (ones % 2 == 1) : (ones % 2 == 0);
      for (int i = 0; i < BC; i++) exp_q.push_back(pb);
    end
    for (int i = 0; i < BC * (s2 ? 2 : 1); i++) exp_q.push_back(1'b1);
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (cap_tx[i] !== logic'(exp_q[i])) return i;
    end
    return -1;
  endfunction

  // Offers one word; returns on the falling edge after the accepting edge.
  task automatic push(input bit sel, input logic [8:0] d, input string tag);
    bit ok;
    ok = 1'b0;
    if (sel) begin s_valid_b = 1'b1; s_data_b = d[4:0]; end
    else     begin s_valid_a = 1'b1; s_data_a = d[7:0]; end
    for (int i = 0; i < 1000 && !ok; i++) begin
      ok = sel ? s_ready_b : s_ready_a;
      @(negedge clk);
    end
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s_accept: s_ready stayed 0 for 1000 cycles, required 1", tag);
    end
  endtask

  task automatic capture(input bit sel, input int n);
    cap_tx.delete();
    cap_busy.delete();
    repeat (n) begin
      cap_tx.push_back(sel ? tx_b : tx_a);
      cap_busy.push_back(sel ? busy_b : busy_a);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    nvec += 5;
    if (tx_a !== 1'b1)      begin nerr++; $display("FAIL reset_tx: got %b want 1", tx_a); end
    if (busy_a !== 1'b0)    begin nerr++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    if (s_ready_a !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b want 0", s_ready_a); end
    if (level_a !== '0)     begin nerr++; $display("FAIL reset_level: got %0d want 0", level_a); end
    if (tx_b !== 1'b1)      begin nerr++; $display("FAIL reset_tx_b: got %b want 1", tx_b); end
    rst = 1'b1;
    @(negedge clk);
    nvec += 2;
    if (s_ready_a !== 1'b1) begin nerr++; $display("FAIL post_reset_ready: got %b want 1", s_ready_a); end
    if (busy_a !== 1'b0)    begin nerr++; $display("FAIL post_reset_busy: got %b want 0", busy_a); end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic();
    int mm, l;
    pen = 1'b0; peven = 1'b0; stop2 = 1'b0;
    l = flen(8, 1'b0, 1'b0);
    push(1'b0, 9'h0A5, "basic");
    exp_q.delete();
    exp_q.push_back(1'b1);
    model_frame(8, 9'h0A5, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(1'b1);
    capture(1'b0, exp_q.size());
    nvec++;
    mm = first_diff();
    if (mm >= 0) begin nerr++; $display("FAIL basic_wave: cycle %0d tx=%b want %b", mm, cap_tx[mm], exp_q[mm]); end
    mm = -1;
    for (int i = 0; i < cap_busy.size(); i++)
      if (mm < 0 && cap_busy[i] !== ((i <= l) ? 1'b1 : 1'b0)) mm = i;
    nvec++;
    if (mm >= 0) begin nerr++; $display("FAIL basic_busy: cycle %0d busy=%b want %b", mm, cap_busy[mm], (mm <= l)); end
    $display("basic: data=a5 frame=%0d cycles", l);
  endtask

  task automatic test_parity();
    int mm;
    for (int k = 0; k < 2; k++) begin
      pen = 1'b1; peven = (k == 0); stop2 = 1'b0;
      push(1'b0, 9'h007, "parity");
      exp_q.delete();
      exp_q.push_back(1'b1);
      model_frame(8, 9'h007, 1'b1, peven, 1'b0);
      exp_q.push_back(1'b1);
      capture(1'b0, exp_q.size());
      nvec += 2;
      mm = first_diff();
      if (mm >= 0) begin nerr++; $display("FAIL parity_wave: peven=%b cycle %0d tx=%b want %b", peven, mm, cap_tx[mm], exp_q[mm]); end
      if (cap_tx[1 + 9 * BC + BC / 2] !== peven)
        begin nerr++; $display("FAIL parity_bit: peven=%b got %b want %b", peven, cap_tx[1 + 9 * BC + BC / 2], peven); end
      $display("parity: data=07 peven=%b frame=%0d cycles", peven, flen(8, 1'b1, 1'b0));
    end
  endtask

  task automatic test_stop2_narrow();
    int mm;
    pen = 1'b0; peven = 1'b0; stop2 = 1'b1;
    push(1'b1, 9'h01F, "narrow");
    exp_q.delete();
    exp_q.push_back(1'b1);
    model_frame(5, 9'h01F, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(1'b1);
    capture(1'b1, exp_q.size());
    nvec += 2;
    mm = first_diff();
    if (mm >= 0) begin nerr++; $display("FAIL narrow_wave: cycle %0d tx=%b want %b", mm, cap_tx[mm], exp_q[mm]); end
    if (cap_busy[80] !== 1'b1 || cap_busy[81] !== 1'b0)
      begin nerr++; $display("FAIL narrow_busy: busy[80]=%b busy[81]=%b want 1,0", cap_busy[80], cap_busy[81]); end
    $display("narrow: data=1f 5 bits, 2 stop, frame=%0d cycles", flen(5, 1'b0, 1'b1));
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[6];
    int idx, first_acc, drop_lvl, mm;
    bit dropped;
    idx = 0; first_acc = 0; drop_lvl = -1; dropped = 1'b0;
    pen = 1'($urandom_range(0, 1)); peven = 1'($urandom_range(0, 1)); stop2 = 1'($urandom_range(0, 1));
    for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    for (int i = 0; i < 6; i++) model_frame(8, {1'b0, w[i]}, pen, peven, stop2);
    exp_q.push_back(1'b1);
    fork
      begin
        s_valid_a = 1'b1;
        s_data_a  = w[0];
        for (int c = 0; c < 2000 && idx < 6; c++) begin
          bit acc;
          acc = s_ready_a;
          if (!acc && !dropped) begin dropped = 1'b1; drop_lvl = int'(level_a); end
          @(negedge clk);
          if (acc) begin
            idx++;
            if (!dropped) first_acc++;
            if (idx < 6) s_data_a = w[idx];
          end
        end
        s_valid_a = 1'b0;
      end
      capture(1'b0, exp_q.size());
    join
    nvec += 5;
    if (first_acc != EXP_FIRST_ACCEPTS) begin nerr++; $display("FAIL btb_accepts: got %0d want %0d", first_acc, EXP_FIRST_ACCEPTS); end
    if (drop_lvl != EXP_DROP_LEVEL)     begin nerr++; $display("FAIL btb_level: got %0d want %0d", drop_lvl, EXP_DROP_LEVEL); end
    if (idx != 6)                       begin nerr++; $display("FAIL btb_count: got %0d words accepted want 6", idx); end
    mm = first_diff();
    if (mm >= 0) begin nerr++; $display("FAIL btb_wave: cycle %0d tx=%b want %b", mm, cap_tx[mm], exp_q[mm]); end
    if (cap_busy[cap_busy.size() - 1] !== 1'b0)
      begin nerr++; $display("FAIL btb_busy_end: got %b want 0", cap_busy[cap_busy.size() - 1]); end
    $display("back_to_back: 6 words pen=%b peven=%b stop2=%b, %0d accepted before stall", pen, peven, stop2, first_acc);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d1, d3;
    time t0;
    int mm;
    pen = 1'b0; peven = 1'b0; stop2 = 1'b0;
    d1 = 8'($urandom) & 8'hF7;
    d3 = 8'($urandom);
    push(1'b0, {1'b0, d1}, "rstmid1");
    t0 = $time;
    push(1'b0, 9'($urandom), "rstmid2");
    while ($time < t0 + 460) @(negedge clk);
    nvec++;
    if (tx_a !== 1'b0) begin nerr++; $display("FAIL rstmid_bit3: got %b want 0", tx_a); end
    rst = 1'b0;
    @(negedge clk);
    nvec += 3;
    if (tx_a !== 1'b1)   begin nerr++; $display("FAIL rstmid_tx: got %b want 1", tx_a); end
    if (level_a !== '0)  begin nerr++; $display("FAIL rstmid_level: got %0d want 0", level_a); end
    if (busy_a !== 1'b0) begin nerr++; $display("FAIL rstmid_busy: got %b want 0", busy_a); end
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(1'b1);
    capture(1'b0, 20);
    nvec += 2;
    mm = first_diff();
    if (mm >= 0) begin nerr++; $display("FAIL rstmid_idle: cycle %0d tx=%b want 1", mm, cap_tx[mm]); end
    if (cap_busy[19] !== 1'b0) begin nerr++; $display("FAIL rstmid_idle_busy: got %b want 0", cap_busy[19]); end
    push(1'b0, {1'b0, d3}, "rstmid3");
    exp_q.delete();
    exp_q.push_back(1'b1);
    model_frame(8, {1'b0, d3}, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(1'b1);
    capture(1'b0, exp_q.size());
    nvec++;
    mm = first_diff();
    if (mm >= 0) begin nerr++; $display("FAIL rstmid_clean: cycle %0d tx=%b want %b", mm, cap_tx[mm], exp_q[mm]); end
    $display("reset_mid: aborted %h, then sent %h", d1, d3);
  endtask

  task automatic test_cfg_change();
    logic [7:0] d1, d2;
    int mm;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    pen = 1'b1; peven = 1'b1; stop2 = 1'b0;
    push(1'b0, {1'b0, d1}, "cfg1");
    exp_q.delete();
    exp_q.push_back(1'b1);
    model_frame(8, {1'b0, d1}, 1'b1, 1'b1, 1'b0);
    model_frame(8, {1'b0, d2}, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(1'b1);
    fork
      capture(1'b0, exp_q.size());
      begin
        push(1'b0, {1'b0, d2}, "cfg2");
        repeat (30) @(negedge clk);
        peven = 1'b0;
        stop2 = 1'b1;
      end
    join
    nvec++;
    mm = first_diff();
    if (mm >= 0) begin nerr++; $display("FAIL cfg_wave: cycle %0d tx=%b want %b", mm, cap_tx[mm], exp_q[mm]); end
    $display("cfg_change: %h even/1 stop then %h odd/2 stop", d1, d2);
  endtask

  task automatic test_random();
    bit sel;
    int nb, mm;
    logic [8:0] d;
    for (int k = 0; k < 8; k++) begin
      sel = 1'($urandom_range(0, 1));
      nb = sel ? 5 : 8;
      d = 9'($urandom) & (sel ? 9'h01F : 9'h0FF);
      pen = 1'($urandom_range(0, 1)); peven = 1'($urandom_range(0, 1)); stop2 = 1'($urandom_range(0, 1));
      push(sel, d, "random");
      exp_q.delete();
      exp_q.push_back(1'b1);
      model_frame(nb, d, pen, peven, stop2);
      exp_q.push_back(1'b1);
      capture(sel, exp_q.size());
      nvec += 2;
      mm = first_diff();
      if (mm >= 0) begin nerr++; $display("FAIL random_wave: dut=%0d data=%h cycle %0d tx=%b want %b", sel, d, mm, cap_tx[mm], exp_q[mm]); end
      if (cap_busy[flen(nb, pen, stop2)] !== 1'b1 || cap_busy[flen(nb, pen, stop2) + 1] !== 1'b0)
        begin nerr++; $display("FAIL random_busy: dut=%0d data=%h busy edge wrong", sel, d); end
      $display("random: dut=%0d data=%h pen=%b peven=%b stop2=%b", sel, d, pen, peven, stop2);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_stop2_narrow();
    test_back_to_back();
    test_reset_mid();
    test_cfg_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
